// File: rtl/dual_issue_controller_pkg.sv
// Shared types and defaults for the dual-issue controller.
//   pipe_sel_t    : target pipe of an instruction (even / odd)
//   issue_state_t : controller state (normal issue / post-branch flush)
//   sb_entry_t    : one scoreboard stage {valid, destination, result latency}
//   raw_hit()     : RAW compare of one source against one scoreboard stage
package dual_issue_controller_pkg;

  localparam int unsigned ADDR_W_DEF    = 7;
  localparam int unsigned LAT_W_DEF     = 3;
  localparam int unsigned DEPTH_DEF     = 7;
  localparam int unsigned FLUSH_CYC_DEF = 2;
  localparam int unsigned CNT_W_DEF     = 16;

  typedef enum logic {
    PIPE_EVEN = 1'b0,
    PIPE_ODD  = 1'b1
  } pipe_sel_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } issue_state_t;

  typedef struct packed {
    logic                  v;
    logic [ADDR_W_DEF-1:0] rt;
    logic [LAT_W_DEF-1:0]  lat;
  } sb_entry_t;

  // A source collides with an in-flight result while that result is still
  // younger than the stage in which it becomes forwardable.
  function automatic logic raw_hit(input sb_entry_t             e,
                                   input int unsigned           stage,
                                   input logic [ADDR_W_DEF-1:0] src,
                                   input logic                  used);
    return used && e.v && (e.rt == src) && (stage < 32'(e.lat));
  endfunction

endpackage

// File: rtl/dual_issue_controller_if.sv
// Decode-side bundle of the dual-issue controller.
//   i0_* / i1_*  : oldest / younger decoded instruction (valid, pipe, ra/rb/rc,
//                  source-used flags {ra,rb,rc}, write flag, rt, result latency)
//   branch_taken : odd-pipe branch resolved taken
//   consumed, ep_issue/ep_slot, op_issue/op_slot, stall, flush_req,
//   stall_count  : issue decision and status returned to decode
// master = decode/testbench side, slave = controller side.
interface dual_issue_controller_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned LAT_W  = 3,
  parameter int unsigned CNT_W  = 16
);
  logic              i0_valid;
  logic              i0_pipe;
  logic [ADDR_W-1:0] i0_ra;
  logic [ADDR_W-1:0] i0_rb;
  logic [ADDR_W-1:0] i0_rc;
  logic [2:0]        i0_use;
  logic              i0_wr;
  logic [ADDR_W-1:0] i0_rt;
  logic [LAT_W-1:0]  i0_lat;

  logic              i1_valid;
  logic              i1_pipe;
  logic [ADDR_W-1:0] i1_ra;
  logic [ADDR_W-1:0] i1_rb;
  logic [ADDR_W-1:0] i1_rc;
  logic [2:0]        i1_use;
  logic              i1_wr;
  logic [ADDR_W-1:0] i1_rt;
  logic [LAT_W-1:0]  i1_lat;

  logic              branch_taken;

  logic [1:0]        consumed;
  logic              ep_issue;
  logic              ep_slot;
  logic              op_issue;
  logic              op_slot;
  logic              stall;
  logic              flush_req;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output i0_valid, i0_pipe, i0_ra, i0_rb, i0_rc, i0_use, i0_wr, i0_rt, i0_lat,
    output i1_valid, i1_pipe, i1_ra, i1_rb, i1_rc, i1_use, i1_wr, i1_rt, i1_lat,
    output branch_taken,
    input  consumed, ep_issue, ep_slot, op_issue, op_slot, stall, flush_req,
    input  stall_count
  );

  modport slave (
    input  i0_valid, i0_pipe, i0_ra, i0_rb, i0_rc, i0_use, i0_wr, i0_rt, i0_lat,
    input  i1_valid, i1_pipe, i1_ra, i1_rb, i1_rc, i1_use, i1_wr, i1_rt, i1_lat,
    input  branch_taken,
    output consumed, ep_issue, ep_slot, op_issue, op_slot, stall, flush_req,
    output stall_count
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Per-pipe shadow of the in-flight pipe stages plus RAW hazard detection.
//   clock, reset         : system clock, synchronous active-high reset
//   ep_load_i, op_load_i : entry entering stage 1 of the even / odd pipe
//   src_i, use_i         : six source addresses and used flags
//                          {i1_ra,i1_rb,i1_rc,i0_ra,i0_rb,i0_rc}
//   haz_o                : per-slot hazard {slot1, slot0}
module issue_scoreboard
  import dual_issue_controller_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  sb_entry_t             ep_load_i,
  input  sb_entry_t             op_load_i,
  input  logic [5:0][ADDR_W-1:0] src_i,
  input  logic [5:0]            use_i,
  output logic [1:0]            haz_o
);

  // Index k holds the instruction issued k+1 cycles ago.
  sb_entry_t ep_q [DEPTH];
  sb_entry_t op_q [DEPTH];
  logic [5:0] hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        ep_q[k] <= '0;
        op_q[k] <= '0;
      end
    end else begin
      ep_q[0] <= ep_load_i;
      op_q[0] <= op_load_i;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        ep_q[k] <= ep_q[k-1];
        op_q[k] <= op_q[k-1];
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int unsigned s = 0; s < 6; s++) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (raw_hit(ep_q[k], k + 32'd1, src_i[s], use_i[s]) ||
            raw_hit(op_q[k], k + 32'd1, src_i[s], use_i[s])) begin
          hit[s] = 1'b1;
        end
      end
    end
  end

  assign haz_o = {|hit[5:3], |hit[2:0]};

endmodule

// File: rtl/dual_issue_controller.sv
// In-order dual-issue scheduler between decode and the even/odd pipes.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : two decoded slots and branch_taken in; issue decision,
//                  stall, flush_req and saturating stall_count out
// Issue outputs are combinational; state, flush counter, scoreboard and
// stall counter are registered. All outputs read 0 while reset is high.
module dual_issue_controller
  import dual_issue_controller_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned LAT_W     = LAT_W_DEF,
  parameter int unsigned FLUSH_CYC = FLUSH_CYC_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  dual_issue_controller_if.slave bus
);

  issue_state_t          state_q, state_d;
  logic [2:0]            flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic [1:0]            haz;
  logic [5:0][ADDR_W-1:0] src;
  logic [5:0]            src_use;

  logic                  i1_struct, i1_dep, i1_waw;
  logic                  run_ok, iss0, iss1;
  logic                  ep_issue, ep_slot, op_issue, op_slot;
  logic                  ep_wr, op_wr;
  logic [ADDR_W-1:0]     ep_rt, op_rt;
  logic [LAT_W-1:0]      ep_lat, op_lat;
  sb_entry_t             ep_load, op_load;
  logic [1:0]            consumed;
  logic                  stall, flush_req;

  // Ordered so that bit s of src_use is the used flag of src[s].
  assign src     = {bus.i1_ra, bus.i1_rb, bus.i1_rc, bus.i0_ra, bus.i0_rb, bus.i0_rc};
  assign src_use = {bus.i1_use, bus.i0_use};

  issue_scoreboard #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_sb (
    .clock     (clock),
    .reset     (reset),
    .ep_load_i (ep_load),
    .op_load_i (op_load),
    .src_i     (src),
    .use_i     (src_use),
    .haz_o     (haz)
  );

  // Issue decision. i1 can only go when i0 goes (in-order), and branch_taken
  // or FLUSH blocks everything.
  always_comb begin
    i1_struct = (bus.i1_pipe != bus.i0_pipe);
    i1_dep    = bus.i0_wr && ((bus.i1_use[2] && (bus.i1_ra == bus.i0_rt)) ||
                              (bus.i1_use[1] && (bus.i1_rb == bus.i0_rt)) ||
                              (bus.i1_use[0] && (bus.i1_rc == bus.i0_rt)));
    i1_waw    = bus.i0_wr && bus.i1_wr && (bus.i1_rt == bus.i0_rt);
    run_ok    = !reset && (state_q == ST_RUN) && !bus.branch_taken;
    iss0      = run_ok && bus.i0_valid && !haz[0];
    iss1      = iss0 && bus.i1_valid && i1_struct && !haz[1] && !i1_dep && !i1_waw;
  end

  // Route issued slots to pipes and build the stage-1 scoreboard entries.
  always_comb begin
    ep_issue = 1'b0;
    ep_slot  = 1'b0;
    op_issue = 1'b0;
    op_slot  = 1'b0;
    if (iss0) begin
      if (pipe_sel_t'(bus.i0_pipe) == PIPE_ODD) op_issue = 1'b1;
      else                                      ep_issue = 1'b1;
    end
    if (iss1) begin
      if (pipe_sel_t'(bus.i1_pipe) == PIPE_ODD) begin
        op_issue = 1'b1;
        op_slot  = 1'b1;
      end else begin
        ep_issue = 1'b1;
        ep_slot  = 1'b1;
      end
    end

    ep_wr  = ep_slot ? bus.i1_wr  : bus.i0_wr;
    ep_rt  = ep_slot ? bus.i1_rt  : bus.i0_rt;
    ep_lat = ep_slot ? bus.i1_lat : bus.i0_lat;
    op_wr  = op_slot ? bus.i1_wr  : bus.i0_wr;
    op_rt  = op_slot ? bus.i1_rt  : bus.i0_rt;
    op_lat = op_slot ? bus.i1_lat : bus.i0_lat;

    ep_load     = '0;
    ep_load.v   = ep_issue && ep_wr;
    ep_load.rt  = ep_rt;
    ep_load.lat = ep_lat;
    op_load     = '0;
    op_load.v   = op_issue && op_wr;
    op_load.rt  = op_rt;
    op_load.lat = op_lat;

    consumed = iss1 ? 2'd2 : (iss0 ? 2'd1 : 2'd0);
    stall    = !reset && bus.i0_valid && !iss0;
  end

  // Flush FSM: branch_taken (re)loads the counter from either state; FLUSH
  // returns to RUN after the cycle in which the counter reads 1.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    flush_req   = 1'b0;
    if (bus.branch_taken) begin
      state_d     = ST_FLUSH;
      flush_cnt_d = 3'(FLUSH_CYC);
      flush_req   = 1'b1;
    end else if (state_q == ST_FLUSH) begin
      if (flush_cnt_q <= 3'd1) state_d = ST_RUN;
      else                     flush_cnt_d = flush_cnt_q - 3'd1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.consumed    = consumed;
  assign bus.ep_issue    = ep_issue;
  assign bus.ep_slot     = ep_slot;
  assign bus.op_issue    = op_issue;
  assign bus.op_slot     = op_slot;
  assign bus.stall       = stall;
  assign bus.flush_req   = flush_req && !reset;
  assign bus.stall_count = reset ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_dual_issue_controller.sv
// Self-checking bench for dual_issue_controller: a table of single-cycle
// pair decisions on an empty scoreboard, then hand-written sequences for
// in-flight RAW, branch flush, reset during flush and counter saturation.
module tb_dual_issue_controller;
  import dual_issue_controller_pkg::*;

  typedef struct packed {
    logic       v;
    logic       p;
    logic [6:0] ra;
    logic [6:0] rb;
    logic [6:0] rc;
    logic [2:0] uses;
    logic       wr;
    logic [6:0] rt;
    logic [2:0] lat;
  } slot_t;

  typedef struct {
    string      name;
    slot_t      s0;
    slot_t      s1;
    int         br;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dual_issue_controller_if #(.ADDR_W(7), .LAT_W(3), .CNT_W(16)) bus ();
  dual_issue_controller_if #(.ADDR_W(7), .LAT_W(3), .CNT_W(4))  bus4 ();

  dual_issue_controller #(
    .ADDR_W(7), .DEPTH(7), .LAT_W(3), .FLUSH_CYC(2), .CNT_W(16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  dual_issue_controller #(
    .ADDR_W(7), .DEPTH(7), .LAT_W(3), .FLUSH_CYC(2), .CNT_W(4)
  ) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  assign bus4.i0_valid     = bus.i0_valid;
  assign bus4.i0_pipe      = bus.i0_pipe;
  assign bus4.i0_ra        = bus.i0_ra;
  assign bus4.i0_rb        = bus.i0_rb;
  assign bus4.i0_rc        = bus.i0_rc;
  assign bus4.i0_use       = bus.i0_use;
  assign bus4.i0_wr        = bus.i0_wr;
  assign bus4.i0_rt        = bus.i0_rt;
  assign bus4.i0_lat       = bus.i0_lat;
  assign bus4.i1_valid     = bus.i1_valid;
  assign bus4.i1_pipe      = bus.i1_pipe;
  assign bus4.i1_ra        = bus.i1_ra;
  assign bus4.i1_rb        = bus.i1_rb;
  assign bus4.i1_rc        = bus.i1_rc;
  assign bus4.i1_use       = bus.i1_use;
  assign bus4.i1_wr        = bus.i1_wr;
  assign bus4.i1_rt        = bus.i1_rt;
  assign bus4.i1_lat       = bus.i1_lat;
  assign bus4.branch_taken = bus.branch_taken;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  vec_t vt[$];

  function automatic slot_t sl(int v, int p, int ra, int rb, int rc,
                               int u, int wr, int rt, int lat);
    slot_t s;
    s.v    = 1'(v);
    s.p    = 1'(p);
    s.ra   = 7'(ra);
    s.rb   = 7'(rb);
    s.rc   = 7'(rc);
    s.uses = 3'(u);
    s.wr   = 1'(wr);
    s.rt   = 7'(rt);
    s.lat  = 3'(lat);
    return s;
  endfunction

  // {consumed, ep_issue, ep_slot, op_issue, op_slot, stall, flush_req}
  function automatic logic [7:0] ex(int c, int e, int es, int o, int os, int st, int fl);
    return {2'(c), 1'(e), 1'(es), 1'(o), 1'(os), 1'(st), 1'(fl)};
  endfunction

  function automatic vec_t mkv(string nm, slot_t a, slot_t b, int br, logic [7:0] e);
    vec_t v;
    v.name = nm;
    v.s0   = a;
    v.s1   = b;
    v.br   = br;
    v.exp  = e;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input slot_t a, input slot_t b, input int br);
    bus.i0_valid     = a.v;
    bus.i0_pipe      = a.p;
    bus.i0_ra        = a.ra;
    bus.i0_rb        = a.rb;
    bus.i0_rc        = a.rc;
    bus.i0_use       = a.uses;
    bus.i0_wr        = a.wr;
    bus.i0_rt        = a.rt;
    bus.i0_lat       = a.lat;
    bus.i1_valid     = b.v;
    bus.i1_pipe      = b.p;
    bus.i1_ra        = b.ra;
    bus.i1_rb        = b.rb;
    bus.i1_rc        = b.rc;
    bus.i1_use       = b.uses;
    bus.i1_wr        = b.wr;
    bus.i1_rt        = b.rt;
    bus.i1_lat       = b.lat;
    bus.branch_taken = (br != 0);
  endtask

  // One clock cycle: drive at posedge+1, expectation queued, outputs
  // compared at the falling edge, then advance past the next rising edge.
  task automatic cycle(input slot_t a, input slot_t b, input int br,
                       input string nm, input logic [7:0] e);
    exp_t x;
    logic [7:0] act;
    drive(a, b, br);
    sb_q.push_back('{nm, e});
    #4;
    x   = sb_q.pop_front();
    act = {bus.consumed, bus.ep_issue, bus.ep_slot, bus.op_issue, bus.op_slot,
           bus.stall, bus.flush_req};
    cmp(x.name, {24'd0, act}, {24'd0, x.exp});
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    drive('0, '0, 0);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cycle(sl(1, 0, 0, 0, 0, 0, 1, 1, 1), sl(1, 1, 0, 0, 0, 0, 0, 0, 1), 1,
          "reset_outputs", 8'h00);
    cmp("reset_stall_count", {16'd0, bus.stall_count}, 32'd0);
    reset = 1'b0;
  endtask

  slot_t idl, pe, po, rd7;

  initial begin
    idl = '0;
    pe  = sl(1, 0, 0, 0, 0, 0, 0, 0, 1);
    po  = sl(1, 1, 0, 0, 0, 0, 0, 0, 1);
    rd7 = sl(1, 0, 7, 0, 0, 4, 0, 0, 1);

    vt.push_back(mkv("pair_split", sl(1,0,0,0,0,0,1,5,1), sl(1,1,9,0,0,4,0,0,1), 0, ex(2,1,0,1,1,0,0)));
    vt.push_back(mkv("struct_even", sl(1,0,0,0,0,0,0,0,1), sl(1,0,0,0,0,0,0,0,1), 0, ex(1,1,0,0,0,0,0)));
    vt.push_back(mkv("struct_odd", sl(1,1,0,0,0,0,0,0,1), sl(1,1,0,0,0,0,0,0,1), 0, ex(1,0,0,1,0,0,0)));
    vt.push_back(mkv("intra_ra", sl(1,0,0,0,0,0,1,3,2), sl(1,1,3,0,0,4,0,0,1), 0, ex(1,1,0,0,0,0,0)));
    vt.push_back(mkv("intra_rb", sl(1,0,0,0,0,0,1,8,1), sl(1,1,0,8,0,2,0,0,1), 0, ex(1,1,0,0,0,0,0)));
    vt.push_back(mkv("intra_rc", sl(1,1,0,0,0,0,1,20,1), sl(1,0,0,0,20,1,0,0,1), 0, ex(1,0,0,1,0,0,0)));
    vt.push_back(mkv("waw", sl(1,0,0,0,0,0,1,4,1), sl(1,1,0,0,0,0,1,4,1), 0, ex(1,1,0,0,0,0,0)));
    vt.push_back(mkv("i0_invalid", idl, sl(1,1,0,0,0,0,0,0,1), 0, ex(0,0,0,0,0,0,0)));
    vt.push_back(mkv("i1_invalid", sl(1,0,0,0,0,0,1,2,1), idl, 0, ex(1,1,0,0,0,0,0)));
    vt.push_back(mkv("odd_first", sl(1,1,0,0,0,0,0,0,1), sl(1,0,0,0,0,0,0,0,1), 0, ex(2,1,1,1,0,0,0)));
    vt.push_back(mkv("src_unused", sl(1,1,0,0,0,0,1,3,3), sl(1,0,3,3,3,0,0,0,1), 0, ex(2,1,1,1,0,0,0)));
    vt.push_back(mkv("i0_nowrite", sl(1,0,0,0,0,0,0,3,1), sl(1,1,3,0,0,4,0,0,1), 0, ex(2,1,0,1,1,0,0)));
    vt.push_back(mkv("distinct_rt", sl(1,1,0,0,0,0,1,6,1), sl(1,0,0,0,0,0,1,7,1), 0, ex(2,1,1,1,0,0,0)));
    vt.push_back(mkv("branch_pair", pe, po, 1, ex(0,0,0,0,0,1,1)));

    drive(idl, idl, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    apply_reset();

    // Table: each vector on an empty scoreboard in RUN.
    foreach (vt[i]) begin
      cycle(vt[i].s0, vt[i].s1, vt[i].br, vt[i].name, vt[i].exp);
      idle(8);
    end

    // In-flight RAW on the even pipe: lat=4 blocks stages 1..3.
    apply_reset();
    cycle(sl(1,0,0,0,0,0,1,10,4), idl, 0, "raw_producer", ex(1,1,0,0,0,0,0));
    for (int k = 1; k <= 3; k++)
      cycle(sl(1,0,10,0,0,4,0,0,1), idl, 0, "raw_stall", ex(0,0,0,0,0,1,0));
    cycle(sl(1,0,10,0,0,4,0,0,1), idl, 0, "raw_release", ex(1,1,0,0,0,0,0));
    cmp("raw_stall_count", {16'd0, bus.stall_count}, 32'd3);

    // Odd-pipe producer blocks only the younger slot; lat=2 frees it at k=2.
    cycle(sl(1,1,0,0,0,0,1,11,2), idl, 0, "odd_producer", ex(1,0,0,1,0,0,0));
    cycle(pe, sl(1,1,11,0,0,4,0,0,1), 0, "odd_raw_i1", ex(1,1,0,0,0,0,0));
    cycle(sl(1,1,11,0,0,4,0,0,1), idl, 0, "odd_raw_clear", ex(1,0,0,1,0,0,0));

    // lat=1 is forwardable immediately: no stall at k=1.
    cycle(sl(1,0,0,0,0,0,1,12,1), idl, 0, "lat1_producer", ex(1,1,0,0,0,0,0));
    cycle(sl(1,0,12,0,0,4,0,0,1), idl, 0, "lat1_no_stall", ex(1,1,0,0,0,0,0));
    idle(8);

    // Branch flush, then a second branch arriving during FLUSH.
    cycle(pe, po, 1, "br_cycle", ex(0,0,0,0,0,1,1));
    cycle(pe, po, 0, "br_flush1", ex(0,0,0,0,0,1,0));
    cycle(pe, po, 0, "br_flush2", ex(0,0,0,0,0,1,0));
    cycle(pe, po, 0, "br_resume", ex(2,1,0,1,1,0,0));
    cycle(pe, po, 1, "br2_cycle", ex(0,0,0,0,0,1,1));
    cycle(pe, po, 1, "br2_reload", ex(0,0,0,0,0,1,1));
    cycle(pe, po, 0, "br2_flush1", ex(0,0,0,0,0,1,0));
    cycle(pe, po, 0, "br2_flush2", ex(0,0,0,0,0,1,0));
    cycle(pe, po, 0, "br2_resume", ex(2,1,0,1,1,0,0));

    // Reset while in FLUSH with rt=7 lat=7 at stage 2.
    cycle(sl(1,0,0,0,0,0,1,7,7), idl, 0, "rst_producer", ex(1,1,0,0,0,0,0));
    cycle(pe, po, 1, "rst_branch", ex(0,0,0,0,0,1,1));
    reset = 1'b1;
    cycle(rd7, po, 1, "rst_outputs_low", ex(0,0,0,0,0,0,0));
    cmp("rst_count_low", {16'd0, bus.stall_count}, 32'd0);
    reset = 1'b0;
    cycle(rd7, idl, 0, "rst_issue_now", ex(1,1,0,0,0,0,0));
    idle(8);

    // Saturation: hold branch_taken with i0 valid so every cycle stalls.
    apply_reset();
    for (int k = 0; k < 14; k++)
      cycle(pe, idl, 1, "sat_stall", ex(0,0,0,0,0,1,1));
    cmp("sat4_at_14", {28'd0, bus4.stall_count}, 32'd14);
    for (int k = 0; k < 6; k++)
      cycle(pe, idl, 1, "sat_stall", ex(0,0,0,0,0,1,1));
    cmp("sat4_held", {28'd0, bus4.stall_count}, 32'd15);
    cmp("cnt16_20", {16'd0, bus.stall_count}, 32'd20);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
